fetch_sequencer: RTL

Fetch-stage controller for the 64-bit RISC-V core. It owns the program counter and drives the instruction-memory read address. It presents fetched words to decode over a valid/ready handshake and applies redirects from execute. On an HCF instruction (R-type, funct7 0000001, funct3 000) it stops fetching and parks in a halt state until reset.

---
 rtl/fetch_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, presents words to decode, applies redirects, halts on HCF.
// Optional accepted-instruction counter enabled by defining FETCH_SEQ_PERF_CNT_EN.
module fetch_sequencer #(
  parameter int unsigned         PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                start,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                halted,
  output logic [1:0]          state,
  output logic [31:0]         fetch_count
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                instr_valid_q, instr_valid_d;
  logic                hcf_pending_q, hcf_pending_d;
  logic                accept;
  logic                is_hcf;
  logic [PC_WIDTH-1:0] redirect_target;

  assign accept = instr_valid_q && instr_ready;
  // HCF: R-type opcode, funct3 000, funct7 0000001; register fields are don't-care.
  assign is_hcf = (imem_data[6:0] == 7'h33) && (imem_data[14:12] == 3'b000) &&
                  (imem_data[31:25] == 7'h01);
  assign redirect_target = redirect_pc & ~{{(PC_WIDTH-2){1'b0}}, 2'b11};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    hcf_pending_d = hcf_pending_q;
    unique case (state_q)
      StIdle: begin
        if (redirect_valid) pc_d = redirect_target;
        if (start) state_d = StRun;
      end
      StRun: begin
        if (redirect_valid) begin
          // A same-cycle accepted word is consumed; the pending HCF is flushed.
          pc_d          = redirect_target;
          instr_valid_d = 1'b0;
          hcf_pending_d = 1'b0;
        end else if (hcf_pending_q && accept) begin
          state_d       = StHalt;
          instr_valid_d = 1'b0;
          hcf_pending_d = 1'b0;
        end else if ((!instr_valid_q || instr_ready) && !hcf_pending_q) begin
          instr_d       = imem_data;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          hcf_pending_d = is_hcf;
          pc_d          = pc_q + PC_WIDTH'(4);
        end
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      hcf_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      hcf_pending_q <= hcf_pending_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = (state_q == StHalt);
  assign state       = state_q;

`ifdef FETCH_SEQ_PERF_CNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      fetch_count_q <= '0;
    end else if (accept && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

endmodule
